fp_add_sequencer: RTL and testbench

//  Upstream driver and downstream collector for the fpbus adder datapath.
//  - Accepts operand pairs on a valid/ready stream and launches them onto fpbus A/B.
//  - Tracks each operation through the fixed-latency adder and captures fpbus Result.
//  - Returns results in order, with tag and class flags, on a valid/ready output stream.
//  - Credit control guarantees every launched result has a FIFO slot, so no result is ever dropped.

---
 rtl/fp_seq_pkg.sv | 27 ++
 rtl/fp_result_fifo.sv | 43 ++++
 rtl/fp_add_sequencer.sv | 101 ++++++++++
 tb/tb_fp_add_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg: fp32 field layout, special-value constants and the class decode
// shared by the add sequencer and its result FIFO.
package fp_seq_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    function automatic fp_class_t fp_class(input fp32_t f);
        fp_class_t c;
        c.zero = (f.exp == 8'h00) && (f.man == '0);
        c.inf  = ({1'b0, f.exp, f.man} == POS_INF);
        c.nan  = (f.exp == EXP_MAX) && (f.man != '0);
        return c;
    endfunction
endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: first-word fall-through sync FIFO of {result, tag};
// pointers carry one extra wrap bit so full and empty are distinguishable.
module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign count_o = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) push_i |-> !full_o);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop_i |-> !empty_o);
endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: launches operand pairs onto the fpbus adder, tracks them through
// its fixed latency and returns results in launch order under credit control.
module fp_add_sequencer
    import fp_seq_pkg::*;
#(
    parameter int ADDER_LATENCY = 0,
    parameter int FIFO_DEPTH    = 4,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      bus_a,
    output logic [31:0]      bus_b,
    input  logic [31:0]      bus_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_inf,
    output logic             out_nan,
    output logic             busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } flight_t;

    flight_t          flight_q [ADDER_LATENCY+1];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      bus_a_q, bus_b_q;
    logic             launch, pop;
    logic             fifo_empty, fifo_full;
    logic [CW-1:0]    fifo_cnt;
    logic [31:0]      head_result;
    logic [TAG_W-1:0] head_tag;
    fp_class_t        head_class;

    assign in_ready = (cnt_q < CW'(FIFO_DEPTH));
    assign launch   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // cnt counts in-flight plus queued ops, so a launch always has a FIFO slot waiting
    always_comb begin
        cnt_d = (launch && !pop) ? cnt_q + 1'b1 : (pop && !launch) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bus_a_q <= '0;
            bus_b_q <= '0;
            for (int i = 0; i <= ADDER_LATENCY; i++) flight_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (launch) begin
                bus_a_q <= in_a;
                bus_b_q <= in_b;
            end
            flight_q[0] <= {launch, in_tag};
            for (int i = 1; i <= ADDER_LATENCY; i++) flight_q[i] <= flight_q[i-1];
        end
    end

    fp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32 + TAG_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (flight_q[ADDER_LATENCY].vld),
        .data_i  ({bus_result, flight_q[ADDER_LATENCY].tag}),
        .pop_i   (pop),
        .data_o  ({head_result, head_tag}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus_a      = bus_a_q;
    assign bus_b      = bus_b_q;
    assign busy       = (cnt_q != '0);
    assign out_valid  = !fifo_empty;
    assign head_class = fp_class(fp32_t'(head_result));
    assign out_result = out_valid ? head_result : '0;
    assign out_tag    = out_valid ? head_tag : '0;
    assign out_zero   = out_valid && head_class.zero;
    assign out_inf    = out_valid && head_class.inf;
    assign out_nan    = out_valid && head_class.nan;

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CW'(FIFO_DEPTH));
    a_credit:    assert property (@(posedge clk) disable iff (!rst_n)
                                  (fifo_cnt <= cnt_q) && (!fifo_full || !in_ready));
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: randomized and directed checks of the add sequencer against
// a queue-based reference model and a behavioural fp32 adder on the fpbus.
module tb_fp_add_sequencer;
    localparam int L  = 0;
    localparam int D  = 4;
    localparam int TW = 4;

    logic          clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
    logic          in_ready, out_valid, out_zero, out_inf, out_nan, busy;
    logic [31:0]   in_a = 0, in_b = 0, bus_a, bus_b, bus_result, out_result;
    logic [TW-1:0] in_tag = 0, out_tag;
    int            total = 0, bad = 0, ecnt = 0;

    typedef struct {
        logic [31:0]   res;
        logic [TW-1:0] tag;
        int            avail;
    } op_t;
    op_t         q[$];
    logic [31:0] ma = 0, mb = 0;

    fp_add_sequencer #(.ADDER_LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .bus_a(bus_a), .bus_b(bus_b),
        .bus_result(bus_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero),
        .out_inf(out_inf), .out_nan(out_nan), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    function automatic logic [63:0] to64(input logic [31:0] f);
        if (f[30:23] == 8'h00) return {f[31], 63'b0};
        if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0], 29'b0};
        return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    endfunction

    // IEEE add via double precision, rounded to nearest-even fp32; subnormals flush to zero
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC00000;
        if (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000 && a[31] != b[31]) return 32'h7FC00000;
        d = $realtobits($bitstoreal(to64(a)) + $bitstoreal(to64(b)));
        if (d[62:52] == 11'h7FF) return {d[63], 31'h7F800000};
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'h0};
        m = {2'b01, d[51:29]} + 25'(d[28] && (d[27:0] != 0 || d[29]));
        if (m[24]) begin
            e++;
            m = m >> 1;
        end
        if (e >= 255) return {d[63], 31'h7F800000};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [2:0] cls(input logic [31:0] r);
        return {r[30:0] == 0, r[30:23] == 8'hFF && r[22:0] == 0, r[30:23] == 8'hFF && r[22:0] != 0};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h7F800000;
            1: return 32'hFF800000;
            2: return 32'h7FC00000;
            3: return 32'h00000000;
            4: return 32'h3F800000;
            default: return $urandom;
        endcase
    endfunction

    assign bus_result = fp_add(bus_a, bus_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: every accepted op sits in q until popped; it becomes visible L+2 edges later
    always @(negedge clk) begin : mon
        bit hv, acc;
        if (!rst_n) begin
            q.delete();
            ma = 0;
            mb = 0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_bus_a", bus_a, 0);
            chk("rst_bus_b", bus_b, 0);
            chk("rst_out_result", out_result, 0);
            chk("rst_out_tag", out_tag, 0);
            chk("rst_flags", {out_zero, out_inf, out_nan}, 0);
        end else begin
            hv  = q.size() != 0 && q[0].avail <= ecnt;
            acc = in_valid && q.size() < D;
            chk("in_ready", in_ready, q.size() < D);
            chk("busy", busy, q.size() != 0);
            chk("out_valid", out_valid, hv);
            chk("bus_a", bus_a, ma);
            chk("bus_b", bus_b, mb);
            if (hv) begin
                chk("result", out_result, q[0].res);
                chk("tag", out_tag, q[0].tag);
                chk("flags", {out_zero, out_inf, out_nan}, cls(q[0].res));
                if (out_ready) void'(q.pop_front());
            end
            if (acc) begin
                q.push_back('{res: fp_add(in_a, in_b), tag: in_tag, avail: ecnt + 2 + L});
                ma = in_a;
                mb = in_b;
            end
        end
    end

    task automatic dir_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic [2:0] f);
        in_a = a; in_b = b; in_tag = 4'hA; in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        repeat (L + 1) tick();
        chk({nm, "_result"}, out_result, r);
        chk({nm, "_flags"}, {out_zero, out_inf, out_nan}, f);
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 0;
        out_ready = 1;
        while ((busy || out_valid) && n < 30) begin
            tick();
            n++;
        end
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        rst_n = 0;
        tick();
        chk("reset_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        tick();
        rst_n = 1;
        tick();

        in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 1; in_valid = 1;
        chk("basic_accept", in_ready, 1);
        tick();
        in_valid = 0;
        chk("basic_bus_a", bus_a, 32'h3F800000);
        chk("basic_bus_b", bus_b, 32'h40000000);
        chk("basic_lat_early", out_valid, 0);
        repeat (L + 1) tick();
        chk("basic_lat", out_valid, 1);
        chk("basic_result", out_result, 32'h40400000);
        chk("basic_tag", out_tag, 1);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("basic_popped", out_valid, 0);

        dir_op("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000, 3'b100);
        dir_op("inf", 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b010);
        dir_op("nan", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001);

        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_tag = TW'(i); in_a = pick(); in_b = pick();
            chk("bp_ready", in_ready, 1);
            tick();
        end
        in_tag = 4;
        chk("bp_full", in_ready, 0);
        chk("bp_busy", busy, 1);
        tick();
        tick();
        chk("bp_still_full", in_ready, 0);
        out_ready = 1;
        tick();
        chk("bp_reopen", in_ready, 1);
        chk("bp_head_tag", out_tag, 1);
        tick();
        in_valid = 0;
        drain();

        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_tag = TW'(i + 5); in_a = pick(); in_b = pick();
            tick();
        end
        in_valid = 0;
        tick();
        tick();
        in_valid = 1; out_ready = 1; in_tag = 9;
        chk("sim_ready_before", in_ready, 1);
        tick();
        in_valid = 0;
        chk("sim_ready_after", in_ready, 1);
        chk("sim_busy", busy, 1);
        drain();

        out_ready = 1;
        in_valid = 1;
        for (int i = 0; i < 24; i++) begin
            in_tag = TW'($urandom); in_a = pick(); in_b = pick();
            chk("stream_ready", in_ready, 1);
            if (i >= 2 + L) chk("stream_valid", out_valid, 1);
            tick();
        end
        drain();

        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            in_tag = TW'($urandom); in_a = pick(); in_b = pick();
            tick();
        end
        drain();

        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_tag = TW'(i + 12); in_a = pick(); in_b = pick();
            tick();
        end
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_bus_a", bus_a, 0);
        chk("midrst_result", out_result, 0);
        tick();
        tick();
        rst_n = 1;
        out_ready = 1;
        repeat (5) begin
            tick();
            chk("post_rst_valid", out_valid, 0);
        end

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
